ps2_keyboard: RTL and testbench
===============================

PS2_KEYBOARD -- requirements
Module: ps2_keyboard

Interface
REQ-001 SHALL have parameter TIMEOUT, default 12000, frame watchdog in CLK12 cycles (1 ms at 12 MHz).
REQ-002 SHALL have parameter FILTER, default 4, consecutive equal samples needed to accept a new PS2_CLK level.
REQ-003 SHALL have port CLK12  input  1  sole clock; all logic is on the rising edge.
REQ-004 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-005 SHALL have port PS2_CLK  input  1  asynchronous keyboard clock line, idle high.
REQ-006 SHALL have port PS2_DAT  input  1  asynchronous keyboard data line, idle high.
REQ-007 SHALL have port KEY_STROBE  output  1  one-cycle pulse marking a new key event.
REQ-008 SHALL have port KEY_PRESSED  output  1  1 = make, 0 = break; valid with KEY_STROBE and held afterwards.
REQ-009 SHALL have port KEY_EXTENDED  output  1  1 = event was E0-prefixed; valid with KEY_STROBE.
REQ-010 SHALL have port KEY_CODE  output  8  set-2 scan code without prefixes; valid with KEY_STROBE.
REQ-011 SHALL have port FRAME_ERR  output  1  one-cycle pulse on a parity, stop-bit or timeout error.

Function
REQ-012 PS2_CLK and PS2_DAT SHALL each pass through a 2-flop synchronizer before any use.
REQ-013 The filtered clock level SHALL change only after FILTER consecutive synchronized samples of the new value.
- A falling edge of the filtered clock SHALL produce a one-cycle edge event.
REQ-014 On each edge event, synchronized PS2_DAT SHALL be sampled.
REQ-015 Frame SHALL be 11 bits: start 0, 8 data bits LSB first, odd parity, stop 1.
REQ-016 The receive FSM SHALL have states IDLE, DATA, PARITY, STOP, with a 3-bit bit counter.
- IDLE, edge, data=0: go to DATA with counter=0.
- IDLE, edge, data=1: ignore and stay in IDLE.
- DATA, edge: shift the bit in; after bit 7 go to PARITY.
- PARITY, edge: store the bit and go to STOP.
- STOP, edge: go to IDLE and validate the frame.
REQ-017 A frame SHALL be valid only if the XOR of the 8 data bits and the parity bit equals 1 and the stop bit equals 1.
- On an invalid frame, FRAME_ERR SHALL pulse one cycle later, the byte SHALL be discarded, and the prefix flags SHALL be cleared.
REQ-018 The watchdog SHALL count CLK12 cycles while not in IDLE and SHALL clear on every edge event.
- On reaching TIMEOUT: go to IDLE, pulse FRAME_ERR, clear the prefix flags.
- If an edge event and the timeout occur in the same cycle, the edge SHALL win.
REQ-019 Valid byte handling SHALL take effect in the cycle after the stop-bit edge event:
- 0xF0 SHALL set break_flag.
- 0xE0 SHALL set ext_flag.
- 0x00, 0xAA, 0xEE, 0xFA, 0xFC, 0xFE and 0xFF SHALL be discarded without changing the flags.
- Any other byte SHALL set KEY_CODE=byte, KEY_PRESSED=~break_flag and KEY_EXTENDED=ext_flag, pulse KEY_STROBE for one cycle, and clear both flags.
REQ-020 KEY_STROBE SHALL never be asserted on two consecutive cycles; FRAME_ERR and KEY_STROBE SHALL never assert together.
REQ-021 KEY_CODE, KEY_PRESSED and KEY_EXTENDED SHALL hold their values between strobes.
REQ-022 The E1 prefix SHALL receive no special handling; the Pause sequence SHALL emit strobes as ordinary bytes.

Reset
REQ-023 While RESET is high, the block SHALL reset as follows:
- FSM to IDLE; counters, flags and watchdog to 0.
- Synchronizers and filter to 1.
- Outputs to KEY_STROBE=0, KEY_PRESSED=0, KEY_EXTENDED=0, KEY_CODE=0x00, FRAME_ERR=0.
REQ-024 RESET asserted mid-frame SHALL abort the frame; the partial frame SHALL produce no strobe and no error.

Verification
REQ-025 Frame 0x1C at 12 kHz PS2_CLK, correct parity -> exactly one KEY_STROBE with KEY_CODE=0x1C, KEY_PRESSED=1, KEY_EXTENDED=0; FRAME_ERR never asserts.
REQ-026 Frames F0, 1C -> no strobe after F0; one strobe with KEY_CODE=0x1C, KEY_PRESSED=0.
- Frames E0, F0, 75 -> one strobe with KEY_CODE=0x75, KEY_PRESSED=0, KEY_EXTENDED=1.
- Next frame 72 -> KEY_EXTENDED=0, KEY_PRESSED=1.
REQ-027 Frame 0x29 with even parity -> FRAME_ERR pulses once, no strobe.
- Next frame 0x29 -> normal strobe (flags cleared).
- Frame 0x29 with stop bit 0 -> FRAME_ERR, no strobe.
REQ-028 Frame stopped after 5 data bits, lines idle for more than TIMEOUT cycles -> FRAME_ERR pulses once, FSM returns to IDLE.
- Following full frame 0x5A -> strobe with KEY_CODE=0x5A.
REQ-029 2-cycle low glitch on PS2_CLK during idle -> no edge event and no state change.
- Frame 0xAA -> no strobe and no error.
REQ-030 RESET asserted for one cycle after data bit 3 of frame F0, then frame 1C -> outputs at reset values.
- Strobe with KEY_CODE=0x1C, KEY_PRESSED=1 (break flag lost).

Source files
------------

// File: rtl/ps2_keyboard.sv
// ps2_keyboard -- PS/2 set-2 keyboard receiver.
//
// Receives 11-bit PS/2 frames (start, 8 data LSB first, odd parity, stop)
// and decodes the E0/F0 prefixes into key events.
//
// Ports:
//   CLK12        in   sole clock, rising edge
//   RESET        in   synchronous, active-high reset
//   PS2_CLK      in   asynchronous keyboard clock line, idle high
//   PS2_DAT      in   asynchronous keyboard data line, idle high
//   KEY_STROBE   out  one-cycle pulse marking a new key event
//   KEY_PRESSED  out  1 = make, 0 = break (held between strobes)
//   KEY_EXTENDED out  1 = event was E0-prefixed (held between strobes)
//   KEY_CODE     out  scan code without prefixes (held between strobes)
//   FRAME_ERR    out  one-cycle pulse on parity, stop-bit or timeout error
//
// Parameters:
//   TIMEOUT  frame watchdog in CLK12 cycles
//   FILTER   consecutive equal samples needed to accept a new PS2_CLK level
module ps2_keyboard #(
  parameter int unsigned TIMEOUT = 12000,
  parameter int unsigned FILTER  = 4
) (
  input  logic       CLK12,
  input  logic       RESET,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic       KEY_STROBE,
  output logic       KEY_PRESSED,
  output logic       KEY_EXTENDED,
  output logic [7:0] KEY_CODE,
  output logic       FRAME_ERR
);

  localparam int unsigned FCW = (FILTER > 1) ? $clog2(FILTER) : 1;
  localparam int unsigned WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  // Synchronizers and clock glitch filter
  logic           clk_meta_q, clk_sync_q;
  logic           dat_meta_q, dat_sync_q;
  logic           clk_filt_q, clk_filt_d;
  logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
  logic           edge_q,     edge_d;

  // Filter: the accepted level only moves after FILTER consecutive
  // synchronized samples that disagree with it; any agreeing sample
  // restarts the run.
  always_comb begin
    clk_filt_d = clk_filt_q;
    filt_cnt_d = filt_cnt_q;
    edge_d     = 1'b0;
    if (clk_sync_q == clk_filt_q) begin
      filt_cnt_d = '0;
    end else if (filt_cnt_q == FCW'(FILTER - 1)) begin
      clk_filt_d = clk_sync_q;
      filt_cnt_d = '0;
      edge_d     = ~clk_sync_q;
    end else begin
      filt_cnt_d = filt_cnt_q + FCW'(1);
    end
  end

  always_ff @(posedge CLK12) begin
    if (RESET) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      clk_filt_q <= 1'b1;
      filt_cnt_q <= '0;
      edge_q     <= 1'b0;
    end else begin
      clk_meta_q <= PS2_CLK;
      clk_sync_q <= clk_meta_q;
      dat_meta_q <= PS2_DAT;
      dat_sync_q <= dat_meta_q;
      clk_filt_q <= clk_filt_d;
      filt_cnt_q <= filt_cnt_d;
      edge_q     <= edge_d;
    end
  end

  // Receive FSM, watchdog and byte decode
  state_e         state_q;
  logic [2:0]     bit_cnt_q;
  logic [7:0]     shift_q;
  logic           parity_q;
  logic [WDW-1:0] wd_q;
  logic           break_q;
  logic           ext_q;
  logic           strobe_q;
  logic           pressed_q;
  logic           extended_q;
  logic [7:0]     code_q;
  logic           err_q;

  logic frame_ok;
  assign frame_ok = (^shift_q ^ parity_q) & dat_sync_q;

  always_ff @(posedge CLK12) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      wd_q       <= '0;
      break_q    <= 1'b0;
      ext_q      <= 1'b0;
      strobe_q   <= 1'b0;
      pressed_q  <= 1'b0;
      extended_q <= 1'b0;
      code_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      err_q    <= 1'b0;
      // An edge event takes priority over a watchdog expiry in the same cycle.
      if (edge_q) begin
        wd_q <= '0;
        case (state_q)
          S_IDLE: begin
            if (!dat_sync_q) begin
              state_q   <= S_DATA;
              bit_cnt_q <= '0;
            end
          end
          S_DATA: begin
            shift_q   <= {dat_sync_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_q <= S_PARITY;
            end
          end
          S_PARITY: begin
            parity_q <= dat_sync_q;
            state_q  <= S_STOP;
          end
          S_STOP: begin
            state_q <= S_IDLE;
            if (frame_ok) begin
              case (shift_q)
                8'hF0: break_q <= 1'b1;
                8'hE0: ext_q   <= 1'b1;
                // Keyboard status/ack bytes: dropped, prefix state untouched.
                8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: ;
                default: begin
                  code_q     <= shift_q;
                  pressed_q  <= ~break_q;
                  extended_q <= ext_q;
                  strobe_q   <= 1'b1;
                  break_q    <= 1'b0;
                  ext_q      <= 1'b0;
                end
              endcase
            end else begin
              err_q   <= 1'b1;
              break_q <= 1'b0;
              ext_q   <= 1'b0;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end else if (state_q != S_IDLE) begin
        if (wd_q == WDW'(TIMEOUT - 1)) begin
          state_q <= S_IDLE;
          wd_q    <= '0;
          err_q   <= 1'b1;
          break_q <= 1'b0;
          ext_q   <= 1'b0;
        end else begin
          wd_q <= wd_q + WDW'(1);
        end
      end
    end
  end

  assign KEY_STROBE   = strobe_q;
  assign KEY_PRESSED  = pressed_q;
  assign KEY_EXTENDED = extended_q;
  assign KEY_CODE     = code_q;
  assign FRAME_ERR    = err_q;

endmodule

// File: tb/tb_ps2_keyboard.sv
// tb_ps2_keyboard -- self-checking bench for ps2_keyboard.
// Frames are driven from a table; expected key events / errors are queued
// when a frame is driven and matched when the DUT pulses its outputs.
module tb_ps2_keyboard;

  localparam int unsigned TO   = 400;
  localparam int unsigned HALF = 40;

  logic       CLK12 = 1'b0;
  logic       RESET = 1'b1;
  logic       PS2_CLK = 1'b1;
  logic       PS2_DAT = 1'b1;
  logic       KEY_STROBE, KEY_PRESSED, KEY_EXTENDED, FRAME_ERR;
  logic [7:0] KEY_CODE;

  ps2_keyboard #(.TIMEOUT(TO), .FILTER(4)) dut (
    .CLK12       (CLK12),
    .RESET       (RESET),
    .PS2_CLK     (PS2_CLK),
    .PS2_DAT     (PS2_DAT),
    .KEY_STROBE  (KEY_STROBE),
    .KEY_PRESSED (KEY_PRESSED),
    .KEY_EXTENDED(KEY_EXTENDED),
    .KEY_CODE    (KEY_CODE),
    .FRAME_ERR   (FRAME_ERR)
  );

  always #5 CLK12 = ~CLK12;

  typedef struct {
    bit         is_err;
    logic [7:0] code;
    bit         pressed;
    bit         ext;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    bit         par_ok;
    bit         stop_ok;
    bit         strobe;
    bit         err;
    bit         pressed;
    bit         ext;
  } vec_t;

  ev_t        exp_q[$];
  int         nvec  = 0;
  int         nfail = 0;
  bit         mon_en = 1'b0;
  bit         prev_strobe = 1'b0;
  logic [7:0] held_code = 8'h00;
  bit         held_pressed = 1'b0;
  bit         held_ext = 1'b0;

  // Event monitor / scoreboard
  always @(negedge CLK12) begin
    if (mon_en) begin
      if (KEY_STROBE && FRAME_ERR) begin
        nvec++; nfail++;
        $display("FAIL strobe_err_overlap: KEY_STROBE and FRAME_ERR both 1, required not both");
      end
      if (KEY_STROBE && prev_strobe) begin
        nvec++; nfail++;
        $display("FAIL strobe_back_to_back: KEY_STROBE high two cycles, required one");
      end
      prev_strobe = KEY_STROBE;
      if (KEY_STROBE || FRAME_ERR) begin
        nvec++;
        if (exp_q.size() == 0) begin
          nfail++;
          $display("FAIL unexpected_event: got strobe=%0b err=%0b code=%02h, required no event",
                   KEY_STROBE, FRAME_ERR, KEY_CODE);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          if (e.is_err) begin
            if (!FRAME_ERR) begin
              nfail++;
              $display("FAIL event_kind: got strobe code=%02h, required FRAME_ERR", KEY_CODE);
            end
          end else if (!KEY_STROBE || KEY_CODE !== e.code || KEY_PRESSED !== e.pressed ||
                       KEY_EXTENDED !== e.ext) begin
            nfail++;
            $display("FAIL key_event: got strobe=%0b code=%02h pressed=%0b ext=%0b, required strobe=1 code=%02h pressed=%0b ext=%0b",
                     KEY_STROBE, KEY_CODE, KEY_PRESSED, KEY_EXTENDED, e.code, e.pressed, e.ext);
          end
        end
      end
    end
  end

  task automatic send_frame(input logic [7:0] d, input bit par_ok, input bit stop_ok,
                            input int nbits);
    logic [10:0] f;
    f = {stop_ok, (par_ok ? ~^d : ^d), d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      PS2_DAT = f[i];
      repeat (HALF / 2) @(negedge CLK12);
      PS2_CLK = 1'b0;
      repeat (HALF) @(negedge CLK12);
      PS2_CLK = 1'b1;
      repeat (HALF / 2) @(negedge CLK12);
    end
    PS2_DAT = 1'b1;
  endtask

  task automatic expect_key(input logic [7:0] c, input bit p, input bit x);
    ev_t e;
    e = '{is_err: 1'b0, code: c, pressed: p, ext: x};
    exp_q.push_back(e);
    held_code = c; held_pressed = p; held_ext = x;
  endtask

  task automatic expect_err();
    ev_t e;
    e = '{is_err: 1'b1, code: 8'h00, pressed: 1'b0, ext: 1'b0};
    exp_q.push_back(e);
  endtask

  task automatic check_idle(input string name);
    nvec++;
    if (exp_q.size() != 0) begin
      nfail++;
      $display("FAIL %s_pending: %0d expected events not seen, required 0", name, exp_q.size());
      exp_q.delete();
    end
    nvec++;
    if (KEY_CODE !== held_code || KEY_PRESSED !== held_pressed || KEY_EXTENDED !== held_ext) begin
      nfail++;
      $display("FAIL %s_hold: got code=%02h pressed=%0b ext=%0b, required code=%02h pressed=%0b ext=%0b",
               name, KEY_CODE, KEY_PRESSED, KEY_EXTENDED, held_code, held_pressed, held_ext);
    end
  endtask

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{8'h1C, 1, 1, 1, 0, 1, 0};
    tbl[1]  = '{8'hF0, 1, 1, 0, 0, 0, 0};
    tbl[2]  = '{8'h1C, 1, 1, 1, 0, 0, 0};
    tbl[3]  = '{8'hE0, 1, 1, 0, 0, 0, 0};
    tbl[4]  = '{8'hF0, 1, 1, 0, 0, 0, 0};
    tbl[5]  = '{8'h75, 1, 1, 1, 0, 0, 1};
    tbl[6]  = '{8'h72, 1, 1, 1, 0, 1, 0};
    tbl[7]  = '{8'h29, 0, 1, 0, 1, 0, 0};
    tbl[8]  = '{8'h29, 1, 1, 1, 0, 1, 0};
    tbl[9]  = '{8'h29, 1, 0, 0, 1, 0, 0};
    tbl[10] = '{8'hE0, 1, 1, 0, 0, 0, 0};
    tbl[11] = '{8'h29, 0, 1, 0, 1, 0, 0};
    tbl[12] = '{8'h29, 1, 1, 1, 0, 1, 0};
    tbl[13] = '{8'hAA, 1, 1, 0, 0, 0, 0};
    tbl[14] = '{8'hE1, 1, 1, 1, 0, 1, 0};
    tbl[15] = '{8'hFA, 1, 1, 0, 0, 0, 0};

    RESET = 1'b1;
    repeat (4) @(negedge CLK12);
    nvec++;
    if (KEY_STROBE !== 1'b0 || KEY_PRESSED !== 1'b0 || KEY_EXTENDED !== 1'b0 ||
        KEY_CODE !== 8'h00 || FRAME_ERR !== 1'b0) begin
      nfail++;
      $display("FAIL reset_state: got strobe=%0b pressed=%0b ext=%0b code=%02h err=%0b, required all 0",
               KEY_STROBE, KEY_PRESSED, KEY_EXTENDED, KEY_CODE, FRAME_ERR);
    end
    RESET = 1'b0;
    mon_en = 1'b1;
    repeat (20) @(negedge CLK12);

    foreach (tbl[i]) begin
      if (tbl[i].strobe) expect_key(tbl[i].data, tbl[i].pressed, tbl[i].ext);
      if (tbl[i].err) expect_err();
      send_frame(tbl[i].data, tbl[i].par_ok, tbl[i].stop_ok, 11);
      repeat (150) @(negedge CLK12);
      check_idle($sformatf("vec%0d", i));
    end

    // Short low glitch on PS2_CLK while idle must not register as an edge.
    PS2_CLK = 1'b0;
    repeat (2) @(negedge CLK12);
    PS2_CLK = 1'b1;
    repeat (100) @(negedge CLK12);
    check_idle("glitch");
    send_frame(8'hAA, 1, 1, 11);
    repeat (150) @(negedge CLK12);
    check_idle("glitch_aa");
    expect_key(8'h1C, 1, 0);
    send_frame(8'h1C, 1, 1, 11);
    repeat (150) @(negedge CLK12);
    check_idle("glitch_after");

    // Truncated frame: start + 5 data bits, then silence past the watchdog.
    expect_err();
    send_frame(8'h5A, 1, 1, 6);
    repeat (TO + 200) @(negedge CLK12);
    check_idle("timeout");
    expect_key(8'h5A, 1, 0);
    send_frame(8'h5A, 1, 1, 11);
    repeat (150) @(negedge CLK12);
    check_idle("timeout_after");

    // Reset after data bit 3 of an F0 frame: frame aborted, break flag lost.
    send_frame(8'hF0, 1, 1, 5);
    RESET = 1'b1;
    @(negedge CLK12);
    RESET = 1'b0;
    held_code = 8'h00; held_pressed = 1'b0; held_ext = 1'b0;
    nvec++;
    if (KEY_STROBE !== 1'b0 || KEY_PRESSED !== 1'b0 || KEY_EXTENDED !== 1'b0 ||
        KEY_CODE !== 8'h00 || FRAME_ERR !== 1'b0) begin
      nfail++;
      $display("FAIL midframe_reset: got strobe=%0b pressed=%0b ext=%0b code=%02h err=%0b, required all 0",
               KEY_STROBE, KEY_PRESSED, KEY_EXTENDED, KEY_CODE, FRAME_ERR);
    end
    repeat (TO + 200) @(negedge CLK12);
    check_idle("reset_quiet");
    expect_key(8'h1C, 1, 0);
    send_frame(8'h1C, 1, 1, 11);
    repeat (150) @(negedge CLK12);
    check_idle("reset_after");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
